// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser on the raw active-low keys,
// then an independent debounce counter per key producing a clean level,
// one-cycle press/release pulses and a press-toggled state bit.
module key_debounce #(
  parameter int N_KEYS    = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  // Terminal count: a level change is accepted on the edge that finds the
  // counter here with the sample still disagreeing with the stable level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;

  // Stage p0/p1: two-flop synchroniser; idles at 1 (released) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [CNT_W-1:0] cnt_p2;
    logic             level_p2;
    logic             press_p2;
    logic             release_p2;
    logic             toggle_p2;
    logic             sample;

    // Synchronised key, converted to active-high "pressed".
    assign sample = ~sync_p1[k];

    // Stage p2: debounce counter; any sample matching the stable level
    // restarts the count, pulses are high only on the accepting edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_p2     <= '0;
        level_p2   <= 1'b0;
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
        toggle_p2  <= 1'b0;
      end else begin
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
        if (sample == level_p2) begin
          cnt_p2 <= '0;
        end else if (cnt_p2 == CNT_MAX) begin
          cnt_p2   <= '0;
          level_p2 <= sample;
          if (sample) begin
            press_p2  <= 1'b1;
            toggle_p2 <= ~toggle_p2;
          end else begin
            release_p2 <= 1'b1;
          end
        end else begin
          cnt_p2 <= cnt_p2 + 1'b1;
        end
      end
    end

    assign key_level[k]   = level_p2;
    assign key_press[k]   = press_p2;
    assign key_release[k] = release_p2;
    assign key_toggle[k]  = toggle_p2;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8: an accepted change
// appears on edge 9 counted from the edge that first samples the new key_n.
module tb_key_debounce;

  localparam int N_KEYS    = 4;
  localparam int DB_CYCLES = 8;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_KEYS-1:0] key_n = '1;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_toggle;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .N_KEYS   (N_KEYS),
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    key_n = '1;
    rst   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key_n = 4'b0000;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({key_level, key_press, key_release, key_toggle} !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got lvl=%b prs=%b rel=%b tog=%b want all 0",
                 i, key_level, key_press, key_release, key_toggle);
      end
    end
    rst = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      total++;
      if (key_level !== ((e >= 9) ? 4'b1111 : 4'b0000)) begin
        bad++;
        $display("FAIL reset_held_level edge %0d: got %b want %b", e, key_level,
                 (e >= 9) ? 4'b1111 : 4'b0000);
      end
      total++;
      if (key_press !== ((e == 9) ? 4'b1111 : 4'b0000)) begin
        bad++;
        $display("FAIL reset_held_press edge %0d: got %b want %b", e, key_press,
                 (e == 9) ? 4'b1111 : 4'b0000);
      end
    end
    total++;
    if (key_toggle !== 4'b1111) begin
      bad++;
      $display("FAIL reset_held_toggle: got %b want 1111", key_toggle);
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    key_n = 4'b1110;
    for (int e = 0; e < 20; e++) begin
      tick();
      total++;
      if (key_level !== ((e >= 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL press_level edge %0d: got %b want %b", e, key_level,
                 (e >= 9) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (key_press !== ((e == 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL press_pulse edge %0d: got %b want %b", e, key_press,
                 (e == 9) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (key_release !== 4'b0000) begin
        bad++;
        $display("FAIL press_no_release edge %0d: got %b want 0000", e, key_release);
      end
    end
    total++;
    if (key_toggle !== 4'b0001) begin
      bad++;
      $display("FAIL press_toggle: got %b want 0001", key_toggle);
    end
  endtask

  // Continues from the clean press: key 0 is held and toggle is 0001.
  task automatic test_release_retoggle();
    key_n = 4'b1111;
    for (int e = 0; e < 12; e++) begin
      tick();
      total++;
      if (key_release !== ((e == 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL release_pulse edge %0d: got %b want %b", e, key_release,
                 (e == 9) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (key_level !== ((e >= 9) ? 4'b0000 : 4'b0001)) begin
        bad++;
        $display("FAIL release_level edge %0d: got %b want %b", e, key_level,
                 (e >= 9) ? 4'b0000 : 4'b0001);
      end
      total++;
      if (key_toggle !== 4'b0001) begin
        bad++;
        $display("FAIL release_toggle_hold edge %0d: got %b want 0001", e, key_toggle);
      end
    end
    key_n = 4'b1110;
    for (int e = 0; e < 12; e++) begin
      tick();
      total++;
      if (key_press !== ((e == 9) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL repress_pulse edge %0d: got %b want %b", e, key_press,
                 (e == 9) ? 4'b0001 : 4'b0000);
      end
    end
    total++;
    if (key_toggle !== 4'b0000) begin
      bad++;
      $display("FAIL repress_toggle: got %b want 0000", key_toggle);
    end
  endtask

  // Low on edges 0-4, high on 5-6, low from edge 7: press lands on edge 16.
  task automatic test_bounce();
    apply_reset();
    for (int e = 0; e < 26; e++) begin
      key_n = (e == 5 || e == 6) ? 4'b1111 : 4'b1101;
      tick();
      total++;
      if (key_press !== ((e == 16) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL bounce_press edge %0d: got %b want %b", e, key_press,
                 (e == 16) ? 4'b0010 : 4'b0000);
      end
      total++;
      if (key_level !== ((e >= 16) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL bounce_level edge %0d: got %b want %b", e, key_level,
                 (e >= 16) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    key_n = 4'b0110;
    for (int e = 0; e < 12; e++) begin
      tick();
      total++;
      if (key_press !== ((e == 9) ? 4'b1001 : 4'b0000)) begin
        bad++;
        $display("FAIL simul_press edge %0d: got %b want %b", e, key_press,
                 (e == 9) ? 4'b1001 : 4'b0000);
      end
    end
    total++;
    if (key_level !== 4'b1001) begin
      bad++;
      $display("FAIL simul_level: got %b want 1001", key_level);
    end
    total++;
    if (key_toggle !== 4'b1001) begin
      bad++;
      $display("FAIL simul_toggle: got %b want 1001", key_toggle);
    end
  endtask

  // Reset on edge 5; first post-reset sample is edge 6, so the press is edge 15.
  task automatic test_reset_midcount();
    apply_reset();
    key_n = 4'b1011;
    for (int e = 0; e < 18; e++) begin
      rst = (e == 5);
      tick();
      total++;
      if (key_press !== ((e == 15) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL midrst_press edge %0d: got %b want %b", e, key_press,
                 (e == 15) ? 4'b0100 : 4'b0000);
      end
      total++;
      if (key_level !== ((e >= 15) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL midrst_level edge %0d: got %b want %b", e, key_level,
                 (e >= 15) ? 4'b0100 : 4'b0000);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_retoggle();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
